sl3p_tx_am_insert: RTL and testbench

SL3P_TX_AM_INSERT -- requirements
Module: sl3p_tx_am_insert

---
 rtl/sl3p_tx_am_insert.sv | 130 +++++++++++++
 tb/tb_sl3p_tx_am_insert.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sl3p_tx_am_insert.sv
// sl3p_tx_am_insert -- alignment-marker inserter for the serdes TX path.
//
// Every emit slot (a cycle in which the registered tx_pempty is high) puts one
// word on all lanes at the same time. The word is a marker on every lane, user
// data on every lane, or idle on every lane. A period is one marker slot
// followed by AM_PERIOD-1 data slots. Lanes are never split across word kinds.
//
// Ports
//   clk        : sole clock (tx_clk_in domain)
//   srst_n     : synchronous active-low reset
//   din        : user words, lane i at [i*66+65:i*66], bits[1:0] sync header
//   din_valid  : din holds a word
//   din_ready  : din is taken on this cycle when din_valid is also high
//   tx_pempty  : serdes TX FIFO is partially empty (room for one more word)
//   dout       : registered words to serdes tx_din
//   dout_valid : serdes tx_valid
//   am_sent    : one-cycle pulse alongside each marker word
//   alias_err  : one-cycle pulse alongside a user word that looks like a marker

// Per-lane helper: builds the lane's marker word and checks the user word
// against the marker signature.
module sl3p_am_lane #(
    parameter int LANE_ID = 0
) (
    input  logic [7:0]  am_seq,
    input  logic [65:0] word,
    output logic [65:0] marker,
    output logic [65:0] idle,
    output logic        sig_hit
);
    always_comb begin
        marker         = '0;
        marker[1:0]    = 2'b01;
        marker[9:2]    = 8'h4B;
        marker[37:34]  = 4'b1100;
        marker[41:38]  = 4'(LANE_ID);
        marker[49:42]  = am_seq;
    end

    always_comb begin
        idle       = '0;
        idle[1:0]  = 2'b01;
        idle[9:2]  = 8'h1E;
    end

    // Only bit 0 and the lane-type nibble identify a marker.
    assign sig_hit = word[0] & (word[37:34] == 4'b1100);
endmodule

module sl3p_tx_am_insert #(
    parameter int LANES     = 2,
    parameter int AM_PERIOD = 16384
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic [LANES*66-1:0]   din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  tx_pempty,
    output logic [LANES*66-1:0]   dout,
    output logic                  dout_valid,
    output logic                  am_sent,
    output logic                  alias_err
);
    localparam logic [15:0] LAST_CNT = 16'(AM_PERIOD - 2);

    typedef enum logic {ST_AM, ST_DATA} state_t;

    state_t              state;
    logic                pempty_q;
    logic [7:0]          am_seq;
    logic [15:0]         word_cnt;
    logic [LANES*66-1:0] marker_w;
    logic [LANES*66-1:0] idle_w;
    logic [LANES-1:0]    hit;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sl3p_am_lane #(.LANE_ID(i)) u_lane (
            .am_seq  (am_seq),
            .word    (din[i*66 +: 66]),
            .marker  (marker_w[i*66 +: 66]),
            .idle    (idle_w[i*66 +: 66]),
            .sig_hit (hit[i])
        );
    end

    // Ready comes only from flops so upstream never sees a din->ready path.
    // In DATA every slot consumes a word if one is offered.
    assign din_ready = (state == ST_DATA) & pempty_q;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state      <= ST_AM;
            pempty_q   <= 1'b0;
            am_seq     <= '0;
            word_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            am_sent    <= 1'b0;
            alias_err  <= 1'b0;
        end else begin
            pempty_q   <= tx_pempty;
            dout_valid <= 1'b0;
            am_sent    <= 1'b0;
            alias_err  <= 1'b0;
            // Outside a slot state and counter are frozen and dout holds.
            if (pempty_q) begin
                dout_valid <= 1'b1;
                if (state == ST_AM) begin
                    dout     <= marker_w;
                    am_sent  <= 1'b1;
                    am_seq   <= am_seq + 8'd1;
                    word_cnt <= '0;
                    state    <= ST_DATA;
                end else begin
                    if (din_valid) begin
                        dout      <= din;
                        alias_err <= |hit;
                    end else begin
                        dout      <= idle_w;
                    end
                    word_cnt <= word_cnt + 16'd1;
                    // Counter ends at AM_PERIOD-1 at most; the marker slot clears it.
                    if (word_cnt == LAST_CNT)
                        state <= ST_AM;
                end
            end
        end
    end
endmodule

// File: tb/tb_sl3p_tx_am_insert.sv
module tb_sl3p_tx_am_insert;
    localparam int L = 2;
    localparam int P = 8;
    localparam int W = L*66;

    logic         clk = 1'b0;
    logic         srst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         tx_pempty;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         am_sent;
    logic         alias_err;

    sl3p_tx_am_insert #(.LANES(L), .AM_PERIOD(P)) dut (
        .clk        (clk),
        .srst_n     (srst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tx_pempty  (tx_pempty),
        .dout       (dout),
        .dout_valid (dout_valid),
        .am_sent    (am_sent),
        .alias_err  (alias_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         am;
        logic         ae;
    } exp_t;

    exp_t         q[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           k      = 0;      // words emitted since reset
    bit           pe_q   = 1'b0;   // model of registered tx_pempty
    logic [W-1:0] next_word;
    int           n_mk   = 0;
    int           n_alias = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] marker_word(input int seq);
        logic [W-1:0] w;
        logic [7:0]   s;
        logic [3:0]   id;
        w = '0;
        s = seq[7:0];
        for (int l = 0; l < L; l++) begin
            id = l[3:0];
            w[l*66]            = 1'b1;
            w[l*66+9 -: 8]     = 8'h4B;
            w[l*66+37 -: 4]    = 4'b1100;
            w[l*66+41 -: 4]    = id;
            w[l*66+49 -: 8]    = s;
        end
        return w;
    endfunction

    function automatic logic [W-1:0] idle_word();
        logic [W-1:0] w;
        w = '0;
        for (int l = 0; l < L; l++) begin
            w[l*66]        = 1'b1;
            w[l*66+9 -: 8] = 8'h1E;
        end
        return w;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        logic [95:0]  t;
        for (int l = 0; l < L; l++) begin
            t = {$urandom(), $urandom(), $urandom()};
            w[l*66 +: 66] = t[65:0];
            w[l*66+1 -: 2] = 2'b10;   // data header, never a marker signature
        end
        return w;
    endfunction

    function automatic logic looks_like_marker(input logic [W-1:0] w);
        logic r;
        r = 1'b0;
        for (int l = 0; l < L; l++)
            if (w[l*66] && w[l*66+37 -: 4] == 4'hC) r = 1'b1;
        return r;
    endfunction

    // One clock: drive, predict, clock, compare.
    task automatic cyc(input bit pe, input bit dv);
        bit   slot, mk, acc;
        exp_t e;
        slot = pe_q;
        mk   = slot && (k % P == 0);
        acc  = slot && !mk && dv;
        tx_pempty = pe;
        din_valid = dv;
        din       = next_word;
        chk("din_ready", W'(din_ready), W'(slot && !mk));
        if (slot) begin
            if (mk) begin
                e.d = marker_word((k / P) % 256); e.am = 1'b1; e.ae = 1'b0;
            end else if (dv) begin
                e.d = next_word; e.am = 1'b0; e.ae = looks_like_marker(next_word);
            end else begin
                e.d = idle_word(); e.am = 1'b0; e.ae = 1'b0;
            end
            q.push_back(e);
            k++;
        end
        @(posedge clk); #1;
        pe_q = pe;
        if (acc) next_word = rand_word();
        chk("dout_valid", W'(dout_valid), W'(slot));
        if (dout_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_word", W'(1), W'(0));
            end else begin
                e = q.pop_front();
                chk("dout", dout, e.d);
                chk("am_sent", W'(am_sent), W'(e.am));
                chk("alias_err", W'(alias_err), W'(e.ae));
                if (e.am) n_mk++;
                if (e.ae) n_alias++;
            end
        end else begin
            q.delete();
            chk("am_sent_idle", W'(am_sent), W'(0));
            chk("alias_err_idle", W'(alias_err), W'(0));
        end
    endtask

    task automatic do_reset();
        srst_n    = 1'b0;
        tx_pempty = 1'b1;
        din_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_dout", dout, '0);
        chk("rst_dout_valid", W'(dout_valid), W'(0));
        chk("rst_din_ready", W'(din_ready), W'(0));
        chk("rst_am_sent", W'(am_sent), W'(0));
        chk("rst_alias_err", W'(alias_err), W'(0));
        srst_n = 1'b1;
        pe_q   = 1'b0;
        k      = 0;
        q.delete();
    endtask

    initial begin
        srst_n    = 1'b0;
        tx_pempty = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        next_word = rand_word();
        #1;
        do_reset();
        do_reset();

        // Idle stream after reset: marker seq 0 on the second cycle, then idles.
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);

        // Continuous user data at full rate.
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1);

        // Throttled by tx_pempty, continuous data.
        for (int i = 0; i < 80; i++) cyc(1'($urandom_range(0, 1)), 1'b1);

        // Aliasing word on lane 1.
        next_word[66]           = 1'b1;
        next_word[66+37 -: 4]   = 4'hC;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        chk("alias_seen", W'(n_alias > 0), W'(1));

        // Reset pulse in the middle of data.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
        do_reset();
        n_mk = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'($urandom_range(0, 1)));

        // Long run to wrap am_seq through 255 -> 0.
        for (int i = 0; i < 2080; i++) cyc(1'b1, 1'($urandom_range(0, 1)));
        chk("marker_count", W'(n_mk), W'((k + P - 1) / P));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
